// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad-side writer for the microwave countdown chain.
// Shifts decimal key presses into a three-digit M:SS entry, validates the
// entry on the start command, then drives a one-cycle active-low load strobe
// followed by a one-cycle start pulse into the digit counters.
//
// Sequence after a start command is accepted at edge N:
//   ARM   : the entry is frozen and no strobe is driven yet (cycle N)
//   LOAD  : loadn is low (cycle N+1), so the counters sample it at edge N+2
//   START : start is high (cycle N+2)
//   then the entry clears at edge N+3 and the block accepts keys again.
// A rejected entry raises err one cycle later than the rejection edge in the
// same way, so both the load strobe and err follow a start command by one cycle.
module time_entry_loader #(
  parameter int KEY_CLEAR = 10,
  parameter int KEY_START = 11
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       start,
  output logic       err,
  output logic [1:0] ndigits
);

  localparam logic [3:0] KC_CLEAR = 4'(KEY_CLEAR);
  localparam logic [3:0] KC_START = 4'(KEY_START);

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_ARM,
    ST_LOAD,
    ST_START
  } state_t;

  state_t state;
  logic   err_pend;

  // Entry register, sequencing FSM and all registered strobes in one block.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_ENTRY;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      ndigits  <= 2'd0;
      loadn    <= 1'b1;
      start    <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      loadn    <= 1'b1;
      start    <= 1'b0;
      err      <= err_pend;
      err_pend <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (!timer_busy && ndigits != 2'd3) begin
                min_ones <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= key_code;
                ndigits  <= ndigits + 2'd1;
              end
            end else if (key_code == KC_CLEAR) begin
              min_ones <= 4'd0;
              sec_tens <= 4'd0;
              sec_ones <= 4'd0;
              ndigits  <= 2'd0;
            end else if (key_code == KC_START && !timer_busy) begin
              if (min_ones == 4'd0 && sec_tens == 4'd0 && sec_ones == 4'd0) begin
                state <= ST_ENTRY;
              end else if (sec_tens > 4'd5) begin
                min_ones <= 4'd0;
                sec_tens <= 4'd0;
                sec_ones <= 4'd0;
                ndigits  <= 2'd0;
                err_pend <= 1'b1;
              end else begin
                state <= ST_ARM;
              end
            end
          end
        end
        ST_ARM: begin
          loadn <= 1'b0;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          start <= 1'b1;
          state <= ST_START;
        end
        ST_START: begin
          min_ones <= 4'd0;
          sec_tens <= 4'd0;
          sec_ones <= 4'd0;
          ndigits  <= 2'd0;
          state    <= ST_ENTRY;
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_loader.sv
// tb_time_entry_loader: table-driven directed vectors followed by random
// key traffic checked against a decimal-arithmetic reference model.
module tb_time_entry_loader;

  logic       clk;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_busy;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       loadn;
  logic       start;
  logic       err;
  logic [1:0] ndigits;

  int checks = 0;
  int errors = 0;

  // Reference model: the entry is held as a plain decimal number 0..999
  int m_value   = 0;
  int m_count   = 0;
  int m_cyc     = 0;
  int m_start_e = -100;
  int m_rej_e   = -100;

  typedef struct {
    logic       clr;
    logic       kv;
    logic [3:0] kc;
    logic       busy;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic       ld;
    logic       sg;
    logic       er;
    logic [1:0] nd;
  } vec_t;

  vec_t vecs[$];

  time_entry_loader #(
    .KEY_CLEAR(10),
    .KEY_START(11)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .timer_busy(timer_busy),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .loadn     (loadn),
    .start     (start),
    .err       (err),
    .ndigits   (ndigits)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advances the model by one rising edge using the inputs seen at that edge
  task automatic model_edge(input logic c, input logic kv, input logic [3:0] kc,
                            input logic busy);
    m_cyc++;
    if (c) begin
      m_value   = 0;
      m_count   = 0;
      m_start_e = -100;
      m_rej_e   = -100;
    end else if (m_cyc <= m_start_e + 3) begin
      if (m_cyc == m_start_e + 3) begin
        m_value = 0;
        m_count = 0;
      end
    end else if (kv) begin
      if (kc <= 4'd9) begin
        if (!busy && m_count < 3) begin
          m_value = (m_value * 10 + int'(kc)) % 1000;
          m_count++;
        end
      end else if (kc == 4'd10) begin
        m_value = 0;
        m_count = 0;
      end else if (kc == 4'd11 && !busy) begin
        if (m_value == 0) begin
          m_value = 0;
        end else if ((m_value / 10) % 10 > 5) begin
          m_value = 0;
          m_count = 0;
          m_rej_e = m_cyc;
        end else begin
          m_start_e = m_cyc;
        end
      end
    end
  endtask

  function automatic logic [16:0] model_outputs();
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       ld;
    logic       sg;
    logic       er;
    d2 = 4'(m_value / 100);
    d1 = 4'((m_value / 10) % 10);
    d0 = 4'(m_value % 10);
    ld = (m_cyc == m_start_e + 1) ? 1'b0 : 1'b1;
    sg = (m_cyc == m_start_e + 2);
    er = (m_cyc == m_rej_e + 1);
    return {d2, d1, d0, ld, sg, er, 2'(m_count)};
  endfunction

  // Drives one cycle of inputs, lets one rising edge pass, then waits for
  // the falling edge so outputs are sampled well away from the active edge
  task automatic applyStimulus(input logic c, input logic kv, input logic [3:0] kc,
                               input logic busy);
    clr        = c;
    key_valid  = kv;
    key_code   = kc;
    timer_busy = busy;
    @(posedge clk);
    model_edge(c, kv, kc, busy);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [16:0] expv);
    logic [16:0] act;
    act = {min_ones, sec_tens, sec_ones, loadn, start, err, ndigits};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got {mo,st,so,loadn,start,err,nd}=%h/%h/%h/%b/%b/%b/%0d expected %h/%h/%h/%b/%b/%b/%0d",
               name, act[16:13], act[12:9], act[8:5], act[4], act[3], act[2], act[1:0],
               expv[16:13], expv[12:9], expv[8:5], expv[4], expv[3], expv[2], expv[1:0]);
    end
  endtask

  task automatic add_vec(input logic c, input logic kv, input logic [3:0] kc,
                         input logic busy, input logic [3:0] mo, input logic [3:0] st,
                         input logic [3:0] so, input logic ld, input logic sg,
                         input logic er, input logic [1:0] nd);
    vecs.push_back('{c, kv, kc, busy, mo, st, so, ld, sg, er, nd});
  endtask

  // Directed table, random traffic, summary
  initial begin
    clr        = 1'b1;
    key_valid  = 1'b0;
    key_code   = 4'd0;
    timer_busy = 1'b0;

    //       clr kv kc     busy  mo st so ld sg er nd
    // reset held for two cycles
    add_vec(1, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    // keys 1,3,0 then start: ARM, LOAD strobe, START pulse, clear
    add_vec(0, 1, 4'd1,  0,    0, 0, 1, 1, 0, 0, 1);
    add_vec(0, 1, 4'd3,  0,    0, 1, 3, 1, 0, 0, 2);
    add_vec(0, 1, 4'd0,  0,    1, 3, 0, 1, 0, 0, 3);
    add_vec(0, 1, 4'd11, 0,    1, 3, 0, 1, 0, 0, 3);
    add_vec(0, 0, 4'd0,  0,    1, 3, 0, 0, 0, 0, 3);
    add_vec(0, 0, 4'd0,  0,    1, 3, 0, 1, 1, 0, 3);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    // keys 2,7,5,9: fourth ignored; start rejected since tens digit is 7
    add_vec(0, 1, 4'd2,  0,    0, 0, 2, 1, 0, 0, 1);
    add_vec(0, 1, 4'd7,  0,    0, 2, 7, 1, 0, 0, 2);
    add_vec(0, 1, 4'd5,  0,    2, 7, 5, 1, 0, 0, 3);
    add_vec(0, 1, 4'd9,  0,    2, 7, 5, 1, 0, 0, 3);
    add_vec(0, 1, 4'd11, 0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 1, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    // start with empty entry is silent
    add_vec(0, 1, 4'd11, 0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    // digits ignored while busy; clear accepted while busy; code 12 ignored
    add_vec(0, 1, 4'd4,  1,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 4'd5,  1,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 4'd1,  0,    0, 0, 1, 1, 0, 0, 1);
    add_vec(0, 1, 4'd10, 1,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 4'd12, 0,    0, 0, 0, 1, 0, 0, 0);
    // start accepted, clr lands on the edge that ends the LOAD cycle
    add_vec(0, 1, 4'd4,  0,    0, 0, 4, 1, 0, 0, 1);
    add_vec(0, 1, 4'd5,  0,    0, 4, 5, 1, 0, 0, 2);
    add_vec(0, 1, 4'd11, 0,    0, 4, 5, 1, 0, 0, 2);
    add_vec(0, 0, 4'd0,  0,    0, 4, 5, 0, 0, 0, 2);
    add_vec(1, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 4'd0,  0,    0, 0, 0, 1, 0, 0, 0);
    // key 8 pressed throughout the load sequence is discarded
    add_vec(0, 1, 4'd2,  0,    0, 0, 2, 1, 0, 0, 1);
    add_vec(0, 1, 4'd11, 0,    0, 0, 2, 1, 0, 0, 1);
    add_vec(0, 1, 4'd8,  0,    0, 0, 2, 0, 0, 0, 1);
    add_vec(0, 1, 4'd8,  0,    0, 0, 2, 1, 1, 0, 1);
    add_vec(0, 1, 4'd8,  0,    0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 4'd8,  0,    0, 0, 8, 1, 0, 0, 1);
    // start while busy is ignored
    add_vec(0, 1, 4'd11, 1,    0, 0, 8, 1, 0, 0, 1);
    add_vec(0, 0, 4'd0,  0,    0, 0, 8, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].clr, vecs[i].kv, vecs[i].kc, vecs[i].busy);
      checkOutput($sformatf("vec%0d", i),
                  {vecs[i].mo, vecs[i].st, vecs[i].so, vecs[i].ld, vecs[i].sg,
                   vecs[i].er, vecs[i].nd});
    end

    for (int i = 0; i < 3000; i++) begin
      logic       c;
      logic       kv;
      logic [3:0] kc;
      logic       busy;
      int         sel;
      c    = ($urandom_range(0, 99) < 2);
      kv   = ($urandom_range(0, 99) < 60);
      busy = ($urandom_range(0, 99) < 15);
      sel  = $urandom_range(0, 11);
      if (sel < 7)       kc = 4'($urandom_range(0, 9));
      else if (sel < 9)  kc = 4'd11;
      else if (sel < 10) kc = 4'd10;
      else               kc = 4'($urandom_range(12, 15));
      applyStimulus(c, kv, kc, busy);
      checkOutput($sformatf("rand%0d", i), model_outputs());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_entry_loader.md
# time_entry_loader

Keypad-side writer for the microwave countdown chain. Accepts decimal key presses, shifts them into a three-digit M:SS entry register, validates the entry on START, and drives the parallel-load interface of the `timer_ten`/mod-6 digit counters. It drives a one-cycle active-low `loadn` strobe with stable BCD data, followed by a one-cycle `start` pulse. It sits between the keypad decoder and the timer chain.

## Interface
- `KEY_CLEAR`, default 10: key code that clears the entry.
- `KEY_START`, default 11: key code that requests load-and-start.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  synchronous reset, active-high.
- `key_valid`  in  1  single-cycle qualifier for `key_code`.
- `key_code`  in  4  0–9 are digits; `KEY_CLEAR` and `KEY_START` are commands; all other codes are ignored.
- `timer_busy`  in  1  high while the countdown chain is running.
- `min_ones`  out  4  BCD minutes digit, drives the minutes counter `in`.
- `sec_tens`  out  4  BCD seconds-tens digit, drives the mod-6 counter `in`.
- `sec_ones`  out  4  BCD seconds-units digit, drives the `timer_ten` `in`.
- `loadn`  out  1  active-low parallel-load strobe to all digit counters.
- `start`  out  1  one-cycle pulse; the enable-latch sets the countdown running.
- `err`  out  1  one-cycle pulse when an entry is rejected.
- `ndigits`  out  2  number of digits entered so far (0–3).

## Operation
- Clock and reset: one clock `clk`; reset `clr` is synchronous and active-high.
- States:
  - ENTRY: accepts keys.
  - LOAD: `loadn` = 0.
  - START: `start` = 1.
  - After START the block returns to ENTRY.
- Reset: `clr` = 1 at an edge forces ENTRY, all digits = 0, `ndigits` = 0, `loadn` = 1, `start` = 0, `err` = 0. Reset overrides any other input in the same cycle.
- Digit key in ENTRY:
  - Accepted only when `timer_busy` = 0 and `ndigits` < 3.
  - On accept: `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← key, `ndigits` ← `ndigits` + 1.
  - A digit key with `ndigits` = 3 or `timer_busy` = 1 is ignored; no state change.
- Clear key in ENTRY: all digits ← 0, `ndigits` ← 0. Accepted regardless of `timer_busy`.
- Start key in ENTRY, evaluated in this priority order:
  1. `timer_busy` = 1: ignored.
  2. All three digits = 0: ignored silently; no `err`.
  3. `sec_tens` > 5: `err` pulses 1 cycle, digits and `ndigits` clear, state stays ENTRY.
  4. Otherwise: go to LOAD.
- LOAD: digits held, `loadn` = 0 for exactly one cycle, then go to START.
- START: digits held, `start` = 1 for exactly one cycle. Then go to ENTRY with digits and `ndigits` cleared.
- `key_valid` during LOAD or START is discarded; keys are not queued.
- Codes 12–15 (and any code other than the two commands) are ignored in all states.
- Digits are stored unmodified. Range checking is limited to the `sec_tens` ≤ 5 test at start.

## Timing
- Outputs are registered; no combinational path exists from inputs to outputs.
- A key accepted at edge N is visible on the digit outputs and `ndigits` after edge N.
- Start accepted at edge N:
  - `loadn` = 0 during cycle N+1 (the counters sample the load at edge N+2).
  - `start` = 1 during cycle N+2.
  - Digits read 0 after edge N+3.
- Digit outputs are stable from edge N through the end of cycle N+2, so the load data never changes while `loadn` = 0.
- A rejected start at edge N: `err` = 1 during cycle N+1 only; digits read 0 after edge N.
- `clr` during LOAD or START: `loadn` returns to 1 and `start` to 0 after that edge. No partial strobe beyond the reset edge.
- Back-to-back `key_valid` on consecutive cycles: every accepted key is captured; no minimum spacing.

## Test plan
- Reset: `clr` = 1 for 2 cycles → all digits 0, `ndigits` = 0, `loadn` = 1, `start` = 0, `err` = 0.
- Keys 1, 3, 0 on consecutive cycles, then START → `min_ones` = 1, `sec_tens` = 3, `sec_ones` = 0. Then one cycle of `loadn` = 0, next cycle `start` = 1, then digits 0 and `ndigits` = 0.
- Keys 2, 7, 5, 9 → the fourth digit is ignored; outputs stay 2:75 with `ndigits` = 3. START → `err` = 1 for one cycle, digits clear, `loadn` stays 1.
- START with empty entry → no `loadn`, no `start`, no `err`. Keys 4, 5 with `timer_busy` = 1 → ignored. CLEAR while busy → digits stay 0.
- START accepted, then `clr` asserted during the LOAD cycle → `loadn` = 1 after that edge, `start` never pulses, all outputs at reset values.
- Key 8 during LOAD or START → discarded; after return to ENTRY, `ndigits` = 0 and `sec_ones` = 0.
